// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the block-RAM arbiter: RAM geometry defaults,
// access kinds and the requester-id width helper.
package ram_arbiter_pkg;

  localparam int RAM_DEPTH      = 1024;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LATENCY = 2;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } accKind_t;

  // A single requester still needs a one-bit id field.
  function automatic int idWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: scans from lastGrant+1 with wrap and
// returns a one-hot grant plus the encoded winner id.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_lastGrant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_winId
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_winId = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(i_lastGrant) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_winId        = w_idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port block RAM between NUM_REQ requesters, one access per
// clock, and routes read data back to the requester after the RAM latency.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata
);

  localparam int ID_W = idWidth(NUM_REQ);

  logic [ID_W-1:0]                  r_lastGrant;
  logic [RD_LATENCY-1:0]            r_pipeValid;
  logic [RD_LATENCY-1:0][ID_W-1:0]  r_pipeId;

  logic [NUM_REQ-1:0]               w_grant;
  logic [ID_W-1:0]                  w_winId;
  logic                             w_accept;
  logic                             w_isWrite;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   w_addrArr;
  logic [NUM_REQ-1:0][DATA_W-1:0]   w_wdataArr;

  assign w_addrArr  = req_addr;
  assign w_wdataArr = req_wdata;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req       (req_valid),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant),
    .o_winId     (w_winId)
  );

  // Reset masks the grant so nothing reaches the RAM while rst is high.
  assign w_accept  = (|w_grant) && !rst;
  assign w_isWrite = (accKind_t'(req_we[w_winId]) == ACC_WRITE);
  assign req_ready = rst ? '0 : w_grant;
  assign ram_en    = w_accept;
  assign ram_we    = w_accept && w_isWrite;
  assign ram_addr  = w_accept ? w_addrArr[w_winId]  : '0;
  assign ram_wdata = w_accept ? w_wdataArr[w_winId] : '0;
  assign rsp_rdata = ram_rdata;

  // Only reads occupy the response pipeline; it mirrors the RAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= ID_W'(NUM_REQ - 1);
      r_pipeValid <= '0;
    end else begin
      if (w_accept) begin
        r_lastGrant <= w_winId;
      end
      r_pipeValid[0] <= w_accept && !w_isWrite;
      r_pipeId[0]    <= w_winId;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeId[i]    <= r_pipeId[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_pipeValid[RD_LATENCY-1] && !rst) begin
      rsp_valid[r_pipeId[RD_LATENCY-1]] = 1'b1;
    end
  end

endmodule
